// File: rtl/accumulating_adder.sv
// accumulating_adder: adds a compile-time constant to each accepted sample and
// accumulates the result into a registered running sum. It supports add or
// subtract per sample, wrap or saturating arithmetic, a sticky overflow flag,
// and a saturating 8-bit count of accepted samples.
//
//   state   | meaning
//   --------+------------------------------------------------
//   IDLE    | no sample accepted last edge, out_valid = 0
//   UPDATED | sum was updated at the last edge, out_valid = 1
module accumulating_adder #(
  parameter int WIDTH     = 4,
  parameter int ACC_WIDTH = 8,
  parameter int CONSTANT  = 0,
  parameter int SATURATE  = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 in_valid,
  input  logic                 subtract,
  input  logic [WIDTH-1:0]     user_number,
  output logic [ACC_WIDTH-1:0] sum,
  output logic                 out_valid,
  output logic                 overflow,
  output logic [7:0]           count
);

  typedef enum logic {
    IDLE    = 1'b0,
    UPDATED = 1'b1
  } state_t;

  localparam logic [ACC_WIDTH:0]   CONST_EXT = (ACC_WIDTH+1)'(CONSTANT);
  localparam logic [ACC_WIDTH-1:0] SUM_MAX   = '1;

  state_t                 state_q;
  state_t                 state_d;
  logic                   accept;
  logic [ACC_WIDTH:0]     operand;
  logic [ACC_WIDTH+1:0]   raw;
  logic                   above;
  logic                   below;
  logic [ACC_WIDTH-1:0]   sum_next;

  assign accept = in_valid & ~reset & ~clear;

  // Operand, raw result and range classification for the incoming sample.
  always_comb begin
    operand  = '0;
    raw      = '0;
    above    = 1'b0;
    below    = 1'b0;
    sum_next = '0;

    operand = {{(ACC_WIDTH+1-WIDTH){1'b0}}, user_number} + CONST_EXT;

    if (subtract) begin
      raw = {2'b00, sum} - {1'b0, operand};
    end else begin
      raw = {2'b00, sum} + {1'b0, operand};
    end

    // An add can reach ~3*2^ACC_WIDTH, which sets the top bit without being
    // negative, so the range test is chosen by direction rather than by
    // treating raw as signed in both cases.
    if (subtract) begin
      below = raw[ACC_WIDTH+1];
    end else begin
      above = (raw[ACC_WIDTH+1:ACC_WIDTH] != 2'b00);
    end

    if (SATURATE != 0) begin
      if (above) begin
        sum_next = SUM_MAX;
      end else if (below) begin
        sum_next = '0;
      end else begin
        sum_next = raw[ACC_WIDTH-1:0];
      end
    end else begin
      sum_next = raw[ACC_WIDTH-1:0];
    end
  end

  // State register; out_valid is decoded straight from it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: any accept lands in UPDATED, anything else returns to IDLE.
  always_comb begin
    state_d = IDLE;
    if (accept) begin
      state_d = UPDATED;
    end
  end

  assign out_valid = (state_q == UPDATED);

  // Accumulator, sticky overflow and accepted-sample counter.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      sum      <= '0;
      overflow <= 1'b0;
      count    <= 8'd0;
    end else if (in_valid) begin
      sum <= sum_next;
      if (above || below) begin
        overflow <= 1'b1;
      end
      if (count != 8'hFF) begin
        count <= count + 8'd1;
      end
    end
  end

endmodule
